// File: rtl/cdc_fifo_1clk.sv
// rtl/cdc_fifo_1clk.sv - single-clock FIFO with registered read data and full/empty flags
module cdc_fifo_1clk #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read_enable,
    output logic [DATA_W-1:0] read_data,
    output logic              fifo_full,
    output logic              fifo_empty
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic              do_write;
    logic              do_read;

    // Extra pointer MSB distinguishes a full buffer from an empty one when the address bits match
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                        (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

    assign do_write = write_enable && !fifo_full;
    assign do_read  = read_enable && !fifo_empty;

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wptr[ADDR_W-1:0]] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            read_data <= '0;
        end else begin
            if (do_write) begin
                wptr <= wptr + 1'b1;
            end
            if (do_read) begin
                read_data <= mem[rptr[ADDR_W-1:0]];
                rptr      <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdc_fifo_1clk.sv
// tb/tb_cdc_fifo_1clk.sv - randomized self-checking bench for cdc_fifo_1clk against a queue model
module tb_cdc_fifo_1clk;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic       write_enable;
    logic [7:0] write_data;
    logic       read_enable;
    logic [7:0] read_data;
    logic       fifo_full;
    logic       fifo_empty;

    int checks = 0;
    int passed = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_rd;
    logic       exp_full;
    logic       exp_empty;

    cdc_fifo_1clk #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one clock of requests and advances the queue model using pre-edge occupancy
    task automatic cycle(input logic we, input logic [7:0] wd, input logic re);
        bit acc_w;
        bit acc_r;
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        acc_w = we && (model_q.size() < DEPTH);
        acc_r = re && (model_q.size() > 0);
        @(posedge clk);
        #1;
        if (acc_r) exp_rd = model_q.pop_front();
        if (acc_w) model_q.push_back(wd);
        exp_full  = (model_q.size() == DEPTH);
        exp_empty = (model_q.size() == 0);
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_rd    = 8'h00;
        exp_full  = 1'b0;
        exp_empty = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        write_data   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if ({fifo_full, fifo_empty, read_data} !== {exp_full, exp_empty, exp_rd})
            $display("FAIL reset full/empty/rd got %b/%b/%h exp %b/%b/%h",
                     fifo_full, fifo_empty, read_data, exp_full, exp_empty, exp_rd);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            checks++;
            if ({fifo_full, fifo_empty} !== {exp_full, exp_empty})
                $display("FAIL fill_flags[%0d] got full=%b empty=%b exp full=%b empty=%b",
                         i, fifo_full, fifo_empty, exp_full, exp_empty);
            else passed++;
        end
        checks++;
        if (fifo_full !== 1'b1) $display("FAIL fill_full got %b exp 1", fifo_full);
        else passed++;
    endtask

    task automatic test_overflow();
        cycle(1'b1, 8'hFF, 1'b0);
        checks++;
        if ({fifo_full, fifo_empty} !== 2'b10)
            $display("FAIL overflow_flags got full=%b empty=%b exp full=1 empty=0", fifo_full, fifo_empty);
        else passed++;
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++;
            if (read_data !== exp_rd || read_data !== 8'(i))
                $display("FAIL drain_data[%0d] got %h exp %h", i, read_data, 8'(i));
            else passed++;
        end
        checks++;
        if ({fifo_full, fifo_empty} !== 2'b01)
            $display("FAIL drain_empty got full=%b empty=%b exp full=0 empty=1", fifo_full, fifo_empty);
        else passed++;
    endtask

    task automatic test_underflow();
        repeat (2) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++;
            if ({read_data, fifo_empty} !== {8'h08, 1'b1})
                $display("FAIL underflow got rd=%h empty=%b exp rd=08 empty=1", read_data, fifo_empty);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        repeat (5) cycle(1'b1, 8'($urandom), 1'b0);
        repeat (5) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++;
            if (read_data !== exp_rd) $display("FAIL wrap_pre got %h exp %h", read_data, exp_rd);
            else passed++;
        end
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0);
        checks++;
        if (fifo_full !== 1'b1) $display("FAIL wrap_full got %b exp 1", fifo_full);
        else passed++;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++;
            if (read_data !== 8'hA0 + 8'(i))
                $display("FAIL wrap_data[%0d] got %h exp %h", i, read_data, 8'hA0 + 8'(i));
            else passed++;
        end
    endtask

    task automatic test_simultaneous();
        repeat (4) cycle(1'b1, 8'($urandom), 1'b0);
        repeat (3) begin
            cycle(1'b1, 8'($urandom), 1'b1);
            checks++;
            if ({read_data, fifo_full, fifo_empty} !== {exp_rd, 2'b00} || model_q.size() != 4)
                $display("FAIL simul_rw got rd=%h full=%b empty=%b exp rd=%h full=0 empty=0",
                         read_data, fifo_full, fifo_empty, exp_rd);
            else passed++;
        end
        // fill to full, then both requested: only the read may happen
        while (model_q.size() < DEPTH) cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b1, 8'hEE, 1'b1);
        checks++;
        if ({read_data, fifo_full} !== {exp_rd, 1'b0})
            $display("FAIL simul_full got rd=%h full=%b exp rd=%h full=0", read_data, fifo_full, exp_rd);
        else passed++;
        while (model_q.size() > 0) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++;
            if (read_data !== exp_rd) $display("FAIL simul_drain got %h exp %h", read_data, exp_rd);
            else passed++;
        end
        // empty with both requested: only the write may happen, read_data holds
        cycle(1'b1, 8'h5C, 1'b1);
        checks++;
        if ({read_data, fifo_empty} !== {exp_rd, 1'b0})
            $display("FAIL simul_empty got rd=%h empty=%b exp rd=%h empty=0", read_data, fifo_empty, exp_rd);
        else passed++;
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (read_data !== 8'h5C) $display("FAIL simul_empty_data got %h exp 5c", read_data);
        else passed++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45));
            checks++;
            if ({read_data, fifo_full, fifo_empty} !== {exp_rd, exp_full, exp_empty}) begin
                if (errs < 10)
                    $display("FAIL random[%0d] got rd=%h full=%b empty=%b exp rd=%h full=%b empty=%b",
                             i, read_data, fifo_full, fifo_empty, exp_rd, exp_full, exp_empty);
                errs++;
            end else passed++;
        end
    endtask

    task automatic test_mid_reset();
        repeat (3) cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({fifo_full, fifo_empty, read_data} !== {exp_full, exp_empty, exp_rd})
            $display("FAIL mid_reset got full=%b empty=%b rd=%h exp full=0 empty=1 rd=00",
                     fifo_full, fifo_empty, read_data);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if ({read_data, fifo_empty} !== {8'h3C, 1'b1})
            $display("FAIL post_reset got rd=%h empty=%b exp rd=3c empty=1", read_data, fifo_empty);
        else passed++;
    endtask

    initial begin
        rst = 1'b1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        write_data   = 8'h00;
        model_reset();
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_wrap();
        test_simultaneous();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
